// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue controller for an external combinational ALU.
// It accepts one request, registers the operands into the ALU, waits one
// cycle for the ALU to settle, captures the result, and holds it until the
// consumer takes it. op_count counts results consumed downstream, mod 256.
// Optional feature: define ALU_ISSUE_ERRCHK_EN to flag divide/modulo by zero
// and undefined opcodes on out_err. The result is forced to zero in that case.
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    input  logic [3:0]  in_sel,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_sel,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        out_zero,
    output logic        out_err,
    output logic [7:0]  op_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  r_state;
    logic [7:0]  r_alu_a;
    logic [7:0]  r_alu_b;
    logic [3:0]  r_alu_sel;
    logic [15:0] r_out_result;
    logic        r_out_zero;
    logic        r_out_err;
    logic [7:0]  r_op_count;

    logic        w_accept;
    logic        w_consume;
    logic [15:0] w_cap_result;
    logic        w_cap_zero;
    logic        w_cap_err;

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = (r_state == S_DONE);
    assign w_accept   = in_ready & in_valid;
    assign w_consume  = out_valid & out_ready;

    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_sel    = r_alu_sel;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_err    = r_out_err;
    assign op_count   = r_op_count;

`ifdef ALU_ISSUE_ERRCHK_EN
    logic w_bad_op;
    // Division by zero and opcodes above EQ produce an error with a zeroed result.
    assign w_bad_op     = (((r_alu_sel == 4'b1001) || (r_alu_sel == 4'b1010)) && (r_alu_b == 8'h00))
                        || (r_alu_sel > 4'b1011);
    assign w_cap_err    = w_bad_op;
    assign w_cap_result = w_bad_op ? 16'h0000 : alu_result;
    assign w_cap_zero   = w_bad_op ? 1'b0 : alu_zero;
`else
    assign w_cap_err    = 1'b0;
    assign w_cap_result = alu_result;
    assign w_cap_zero   = alu_zero;
`endif

    // Control FSM. DONE goes back to IDLE without looking at in_valid, so a
    // new request cannot be taken in the cycle a result is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) r_state <= S_EXEC;
                S_EXEC:  r_state <= S_DONE;
                S_DONE:  if (out_ready) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ALU operand registers change only when a request is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_a   <= 8'h00;
            r_alu_b   <= 8'h00;
            r_alu_sel <= 4'h0;
        end else if (w_accept) begin
            r_alu_a   <= in_a;
            r_alu_b   <= in_b;
            r_alu_sel <= in_sel;
        end
    end

    // Capture the settled ALU outputs at the end of EXEC and hold them through DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_result <= 16'h0000;
            r_out_zero   <= 1'b0;
            r_out_err    <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_out_result <= w_cap_result;
            r_out_zero   <= w_cap_zero;
            r_out_err    <= w_cap_err;
        end
    end

    // Count results taken downstream. The counter wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= 8'h00;
        end else if (w_consume) begin
            r_op_count <= r_op_count + 8'h01;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: an emulated combinational ALU, a transaction-level
// reference model, a per-cycle compare process, directed literal cases, and
// randomized traffic with occasional asynchronous resets.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = 8'h00;
    logic [7:0]  in_b = 8'h00;
    logic [3:0]  in_sel = 4'h0;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [15:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_result;
    logic        out_zero;
    logic        out_err;
    logic [7:0]  op_count;

    int n_chk = 0;
    int n_err = 0;

    alu_issue_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_err(out_err),
        .op_count(op_count)
    );

    always #5 clk = ~clk;

    // External ALU behaviour. Divide and modulo by zero return arbitrary values.
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        logic [15:0] wa;
        logic [15:0] wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (s)
            4'd0:    return wa + wb;
            4'd1:    return wa - wb;
            4'd2:    return wa & wb;
            4'd3:    return wa | wb;
            4'd4:    return wa ^ wb;
            4'd5:    return {8'h00, ~a};
            4'd6:    return wa << b[3:0];
            4'd7:    return wa >> b[3:0];
            4'd8:    return wa * wb;
            4'd9:    return (b == 8'h00) ? 16'hFFFF : wa / wb;
            4'd10:   return (b == 8'h00) ? wa : wa % wb;
            4'd11:   return {15'h0, a == b};
            default: return 16'h0000;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_a, alu_b, alu_sel);
        alu_zero   = (alu_result == 16'h0000);
    end

    // Expected capture for an operation: {err, zero, result}.
    function automatic logic [17:0] expect_cap(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        logic [15:0] r;
        r = alu_fn(a, b, s);
`ifdef ALU_ISSUE_ERRCHK_EN
        if (((s == 4'd9 || s == 4'd10) && b == 8'h00) || s > 4'd11)
            return {1'b1, 1'b0, 16'h0000};
`endif
        return {1'b0, r == 16'h0000, r};
    endfunction

    // Reference model. At most one operation is in flight. It completes
    // one edge after it is accepted and retires on the first edge with
    // out_ready set after that.
    logic        m_busy, m_have_res;
    logic [7:0]  m_a, m_b;
    logic [3:0]  m_sel;
    logic [17:0] m_cap;
    logic [7:0]  m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_have_res <= 1'b0;
            m_a <= 8'h00; m_b <= 8'h00; m_sel <= 4'h0;
            m_cap <= 18'h0; m_cnt <= 8'h00;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy <= 1'b1; m_have_res <= 1'b0;
                m_a <= in_a; m_b <= in_b; m_sel <= in_sel;
            end
        end else if (!m_have_res) begin
            m_have_res <= 1'b1;
            m_cap <= expect_cap(m_a, m_b, m_sel);
        end else if (out_ready) begin
            m_busy <= 1'b0;
            m_cnt  <= m_cnt + 8'h01;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every DUT output with the model on each falling edge.
    always @(negedge clk) begin
        chk("sb_in_ready",  {31'h0, in_ready},  {31'h0, !m_busy});
        chk("sb_out_valid", {31'h0, out_valid}, {31'h0, m_busy && m_have_res});
        chk("sb_alu_a",     {24'h0, alu_a},     {24'h0, m_a});
        chk("sb_alu_b",     {24'h0, alu_b},     {24'h0, m_b});
        chk("sb_alu_sel",   {28'h0, alu_sel},   {28'h0, m_sel});
        chk("sb_result",    {16'h0, out_result},{16'h0, m_cap[15:0]});
        chk("sb_zero",      {31'h0, out_zero},  {31'h0, m_cap[16]});
        chk("sb_err",       {31'h0, out_err},   {31'h0, m_cap[17]});
        chk("sb_op_count",  {24'h0, op_count},  {24'h0, m_cnt});
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present one request and check the two-edge latency. Returns in DONE.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
        int n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        chk("issue_ready", {31'h0, in_ready}, 32'h1);
        in_valid = 1'b1; in_a = a; in_b = b; in_sel = s;
        step();
        in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom); in_sel = 4'($urandom);
        chk("lat_edge1_valid", {31'h0, out_valid}, 32'h0);
        step();
        chk("lat_edge2_valid", {31'h0, out_valid}, 32'h1);
    endtask

    initial begin
        logic [7:0] c0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_op_count", {24'h0, op_count}, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // Reset arriving during EXEC drops the operation.
        in_valid = 1'b1; in_a = 8'd10; in_b = 8'd5; in_sel = 4'd0;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("exec_rst_valid",  {31'h0, out_valid}, 32'h0);
        chk("exec_rst_alu_a",  {24'h0, alu_a},     32'h0);
        chk("exec_rst_result", {16'h0, out_result},32'h0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("exec_rst_novalid", {31'h0, out_valid}, 32'h0);
        chk("exec_rst_count",   {24'h0, op_count},  32'h0);

        // ADD 10+5
        out_ready = 1'b1;
        issue(8'd10, 8'd5, 4'd0);
        chk("add_result", {16'h0, out_result}, 32'd15);
        chk("add_zero",   {31'h0, out_zero},   32'h0);
        chk("add_count0", {24'h0, op_count},   32'h0);
        step();
        chk("add_count1", {24'h0, op_count},   32'h1);

        // SUB 5-5
        issue(8'd5, 8'd5, 4'd1);
        chk("sub_result", {16'h0, out_result}, 32'h0);
        chk("sub_zero",   {31'h0, out_zero},   32'h1);
        step();

        // MUL with backpressure for 3 cycles
        out_ready = 1'b0;
        issue(8'd10, 8'd5, 4'd8);
        for (int i = 0; i < 3; i++) begin
            chk("mul_hold_result", {16'h0, out_result}, 32'd50);
            chk("mul_hold_ready",  {31'h0, in_ready},   32'h0);
            step();
        end
        chk("mul_hold_result", {16'h0, out_result}, 32'd50);
        out_ready = 1'b1;
        step();
        chk("mul_idle",  {31'h0, in_ready}, 32'h1);
        chk("mul_count", {24'h0, op_count}, 32'h3);

        // Divide by zero and an undefined opcode
        issue(8'd10, 8'd0, 4'd9);
`ifdef ALU_ISSUE_ERRCHK_EN
        chk("div0_err",    {31'h0, out_err},    32'h1);
        chk("div0_result", {16'h0, out_result}, 32'h0);
`else
        chk("div0_err",    {31'h0, out_err},    32'h0);
        chk("div0_result", {16'h0, out_result}, 32'hFFFF);
`endif
        step();
        issue(8'd10, 8'd5, 4'd12);
`ifdef ALU_ISSUE_ERRCHK_EN
        chk("badop_err", {31'h0, out_err}, 32'h1);
`else
        chk("badop_err", {31'h0, out_err}, 32'h0);
`endif
        step();

        // 256 consecutive operations bring op_count back to its start value.
        c0 = op_count;
        for (int i = 0; i < 256; i++) begin
            issue(8'($urandom), 8'($urandom), 4'($urandom_range(0, 11)));
            step();
        end
        chk("wrap_count", {24'h0, op_count}, {24'h0, c0});

        // Random traffic. in_valid and operands also change while the block is busy.
        for (int i = 0; i < 3000; i++) begin
            step();
            rst_n     = ($urandom_range(0, 299) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_a      = 8'($urandom);
            in_b      = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            in_sel    = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 6);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
